// File: rtl/maze_walker_if.sv
// rtl/maze_walker_if.sv - map ROM, move handshake and status bundle for maze_walker
interface maze_walker_if;
    logic       start;
    logic       rom_en;
    logic [2:0] rom_addr;
    logic [8:0] rom_data;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ready;
    logic       move_done;
    logic       move_ok;
    logic [2:0] pos_x;
    logic [2:0] pos_y;
    logic       loaded;
    logic       at_goal;
    logic       err;

    // Walker side: consumes start/ROM data/moves, produces everything else.
    modport slave (
        input  start, rom_data, move_valid, move_dir,
        output rom_en, rom_addr, move_ready, move_done, move_ok,
               pos_x, pos_y, loaded, at_goal, err
    );

    // Controller / ROM side.
    modport master (
        output start, rom_data, move_valid, move_dir,
        input  rom_en, rom_addr, move_ready, move_done, move_ok,
               pos_x, pos_y, loaded, at_goal, err
    );
endinterface

// File: rtl/maze_walker.sv
// rtl/maze_walker.sv - loads an 8x8 maze from ROM and tracks player moves to the goal
module maze_walker #(
    parameter logic [2:0] START_X = 3'd0,
    parameter logic [2:0] START_Y = 3'd0,
    parameter logic [2:0] GOAL_X  = 3'd7,
    parameter logic [2:0] GOAL_Y  = 3'd7
) (
    input  logic         clk,
    input  logic         rst,
    maze_walker_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        PLAY,
        GOAL,
        ERR
    } state_t;

    state_t     state;
    logic [7:0] cells [8];     // cells[y][x], 1 = open

    // ROM has one cycle of latency: remember which row the data now on
    // rom_data belongs to.
    logic       cap_valid;
    logic [2:0] cap_row;

    logic       restart;
    logic       tgt_in;
    logic [2:0] tgt_x;
    logic [2:0] tgt_y;
    logic       tgt_ok;
    logic       tgt_goal;

    // Column 8 of each ROM row carries no maze information.
    logic       unused_rom_bit8;
    assign unused_rom_bit8 = bus.rom_data[8];

    // Start (re)loads from every state except while a load/check is in flight.
    always_comb begin
        restart = 1'b0;
        if (bus.start && (state == IDLE || state == PLAY || state == GOAL || state == ERR)) begin
            restart = 1'b1;
        end
    end

    // Target cell for the requested move; off-board targets are never open.
    always_comb begin
        tgt_x  = bus.pos_x;
        tgt_y  = bus.pos_y;
        tgt_in = 1'b0;
        case (bus.move_dir)
            2'b00: begin
                tgt_in = (bus.pos_y != 3'd0);
                tgt_y  = bus.pos_y - 3'd1;
            end
            2'b01: begin
                tgt_in = (bus.pos_y != 3'd7);
                tgt_y  = bus.pos_y + 3'd1;
            end
            2'b10: begin
                tgt_in = (bus.pos_x != 3'd0);
                tgt_x  = bus.pos_x - 3'd1;
            end
            default: begin
                tgt_in = (bus.pos_x != 3'd7);
                tgt_x  = bus.pos_x + 3'd1;
            end
        endcase
        tgt_ok   = tgt_in && cells[tgt_y][tgt_x];
        tgt_goal = (tgt_x == GOAL_X) && (tgt_y == GOAL_Y);
    end

    // Main controller: map load sequencing, start-cell check and move handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.rom_en     <= 1'b0;
            bus.rom_addr   <= 3'd0;
            bus.move_ready <= 1'b0;
            bus.move_done  <= 1'b0;
            bus.move_ok    <= 1'b0;
            bus.pos_x      <= START_X;
            bus.pos_y      <= START_Y;
            bus.loaded     <= 1'b0;
            bus.at_goal    <= 1'b0;
            bus.err        <= 1'b0;
            cap_valid      <= 1'b0;
            cap_row        <= 3'd0;
            for (int r = 0; r < 8; r++) begin
                cells[r] <= 8'h00;
            end
        end else begin
            bus.move_done <= 1'b0;
            if (restart) begin
                state          <= LOAD;
                bus.rom_en     <= 1'b1;
                bus.rom_addr   <= 3'd0;
                cap_valid      <= 1'b0;
                bus.move_ready <= 1'b0;
                bus.move_ok    <= 1'b0;
                bus.loaded     <= 1'b0;
                bus.at_goal    <= 1'b0;
                bus.err        <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (bus.rom_en) begin
                            if (bus.rom_addr == 3'd7) begin
                                bus.rom_en <= 1'b0;
                            end else begin
                                bus.rom_addr <= bus.rom_addr + 3'd1;
                            end
                        end
                        cap_valid <= bus.rom_en;
                        cap_row   <= bus.rom_addr;
                        if (cap_valid) begin
                            cells[cap_row] <= bus.rom_data[7:0];
                            if (cap_row == 3'd7) begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        bus.pos_x <= START_X;
                        bus.pos_y <= START_Y;
                        if (cells[START_Y][START_X]) begin
                            state          <= PLAY;
                            bus.loaded     <= 1'b1;
                            bus.move_ready <= 1'b1;
                            bus.at_goal    <= (START_X == GOAL_X) && (START_Y == GOAL_Y);
                        end else begin
                            state   <= ERR;
                            bus.err <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (bus.move_valid) begin
                            bus.move_done <= 1'b1;
                            bus.move_ok   <= tgt_ok;
                            if (tgt_ok) begin
                                bus.pos_x   <= tgt_x;
                                bus.pos_y   <= tgt_y;
                                bus.at_goal <= tgt_goal;
                                if (tgt_goal) begin
                                    state          <= GOAL;
                                    bus.move_ready <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        // IDLE, GOAL and ERR only leave on start.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_maze_walker.sv
// tb/tb_maze_walker.sv - self-checking bench for maze_walker against a grid walk model
module tb_maze_walker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maze_walker_if bus();

    maze_walker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Map ROM: synchronous read, one cycle latency, bit 8 is random junk.
    logic [7:0] map [8];
    always @(posedge clk) begin
        if (bus.rom_en) begin
            bus.rom_data <= {1'($urandom_range(0, 1)), map[bus.rom_addr]};
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: player position on a grid plus game flags.
    int mx, my;
    bit m_loaded, m_err, m_goal, m_ok;
    logic [1:0] dq[$];

    function automatic bit model_step(input logic [1:0] d, output int nx, output int ny);
        nx = mx;
        ny = my;
        case (d)
            2'd0: ny = my - 1;
            2'd1: ny = my + 1;
            2'd2: nx = mx - 1;
            default: nx = mx + 1;
        endcase
        if (nx < 0 || nx > 7 || ny < 0 || ny > 7) return 1'b0;
        return map[ny][nx];
    endfunction

    task automatic model_reset();
        mx = 0; my = 0;
        m_loaded = 0; m_err = 0; m_goal = 0; m_ok = 0;
    endtask

    task automatic set_map(input logic [63:0] rows);
        for (int r = 0; r < 8; r++) map[r] = rows[r*8 +: 8];
    endtask

    // Start pulse (optionally with a simultaneous move) and full load sequence.
    task automatic do_load(input string name, input bit with_move);
        int px, py;
        bit exp_open;
        px = mx; py = my;
        bus.start = 1'b1;
        bus.move_valid = with_move;
        bus.move_dir = 2'($urandom_range(0, 3));
        @(negedge clk);
        bus.start = 1'b0;
        bus.move_valid = 1'b0;
        m_ok = 0;
        n_chk++;
        if (bus.move_done !== 1'b0 || bus.loaded !== 1'b0 || bus.at_goal !== 1'b0 ||
            bus.err !== 1'b0 || bus.move_ready !== 1'b0 || bus.move_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_clear: done=%b loaded=%b goal=%b err=%b ready=%b ok=%b want all 0",
                     name, bus.move_done, bus.loaded, bus.at_goal, bus.err, bus.move_ready, bus.move_ok);
        end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            n_chk++;
            if (bus.rom_en !== 1'b1 || bus.rom_addr !== 3'(i)) begin
                n_fail++;
                $display("FAIL %s rom_cycle%0d: en=%b addr=%0d want en=1 addr=%0d",
                         name, i + 1, bus.rom_en, bus.rom_addr, i);
            end
        end
        @(negedge clk);
        n_chk++;
        if (bus.rom_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s rom_en_fall: got %b want 0", name, bus.rom_en);
        end
        @(negedge clk);
        n_chk++;
        if (bus.loaded !== 1'b0 || bus.err !== 1'b0 || bus.pos_x !== 3'(px) || bus.pos_y !== 3'(py)) begin
            n_fail++;
            $display("FAIL %s check_cycle: loaded=%b err=%b pos=(%0d,%0d) want 0 0 (%0d,%0d)",
                     name, bus.loaded, bus.err, bus.pos_x, bus.pos_y, px, py);
        end
        @(negedge clk);
        exp_open = map[0][0];
        mx = 0; my = 0; m_goal = 0;
        m_loaded = exp_open;
        m_err = !exp_open;
        n_chk++;
        if (bus.loaded !== m_loaded || bus.err !== m_err || bus.move_ready !== m_loaded ||
            bus.pos_x !== 3'd0 || bus.pos_y !== 3'd0 || bus.at_goal !== 1'b0) begin
            n_fail++;
            $display("FAIL %s loaded: loaded=%b err=%b ready=%b pos=(%0d,%0d) goal=%b want %b %b %b (0,0) 0",
                     name, bus.loaded, bus.err, bus.move_ready, bus.pos_x, bus.pos_y, bus.at_goal,
                     m_loaded, m_err, m_loaded);
        end
    endtask

    // Issue the moves in dq back-to-back, checking each against the model.
    task automatic do_moves(input string name);
        int nx, ny;
        bit exp_ready, ok;
        foreach (dq[i]) begin
            exp_ready = m_loaded && !m_goal;
            n_chk++;
            if (bus.move_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL %s ready%0d: got %b want %b", name, i, bus.move_ready, exp_ready);
            end
            bus.move_valid = 1'b1;
            bus.move_dir = dq[i];
            @(negedge clk);
            if (exp_ready) begin
                ok = model_step(dq[i], nx, ny);
                m_ok = ok;
                if (ok) begin
                    mx = nx; my = ny;
                    m_goal = (mx == 7 && my == 7);
                end
            end
            n_chk++;
            if (bus.move_done !== exp_ready || bus.move_ok !== m_ok || bus.pos_x !== 3'(mx) ||
                bus.pos_y !== 3'(my) || bus.at_goal !== m_goal) begin
                n_fail++;
                $display("FAIL %s move%0d dir=%0d: done=%b ok=%b pos=(%0d,%0d) goal=%b want %b %b (%0d,%0d) %b",
                         name, i, dq[i], bus.move_done, bus.move_ok, bus.pos_x, bus.pos_y, bus.at_goal,
                         exp_ready, m_ok, mx, my, m_goal);
            end
        end
        bus.move_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++;
        if (bus.rom_en !== 1'b0 || bus.rom_addr !== 3'd0 || bus.move_ready !== 1'b0 ||
            bus.move_done !== 1'b0 || bus.move_ok !== 1'b0 || bus.pos_x !== 3'd0 ||
            bus.pos_y !== 3'd0 || bus.loaded !== 1'b0 || bus.at_goal !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: en=%b addr=%0d ready=%b done=%b ok=%b pos=(%0d,%0d) loaded=%b goal=%b err=%b want all 0",
                     bus.rom_en, bus.rom_addr, bus.move_ready, bus.move_done, bus.move_ok,
                     bus.pos_x, bus.pos_y, bus.loaded, bus.at_goal, bus.err);
        end
    endtask

    task automatic test_standard_map();
        set_map(64'hE4B6928EEA27FC0F);
        do_load("std_load", 1'b0);
        dq = {2'b11, 2'b00};
        do_moves("std_right_up");
        n_chk++;
        if (bus.pos_x !== 3'd1 || bus.pos_y !== 3'd0 || bus.move_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL std_up_blocked: pos=(%0d,%0d) ok=%b want (1,0) 0", bus.pos_x, bus.pos_y, bus.move_ok);
        end
        do_load("std_reload_with_move", 1'b1);
        dq = {2'b01, 2'b11, 2'b11, 2'b01};
        do_moves("std_down_rrd");
        n_chk++;
        if (bus.pos_x !== 3'd2 || bus.pos_y !== 3'd1 || bus.move_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL std_path: pos=(%0d,%0d) ok=%b want (2,1) 1", bus.pos_x, bus.pos_y, bus.move_ok);
        end
    endtask

    task automatic test_back_to_back_goal();
        set_map({8{8'hFF}});
        do_load("ones_load", 1'b0);
        dq = {};
        for (int i = 0; i < 7; i++) dq.push_back(2'b11);
        for (int i = 0; i < 7; i++) dq.push_back(2'b01);
        dq.push_back(2'b10);
        dq.push_back(2'b00);
        do_moves("ones_to_goal");
        n_chk++;
        if (bus.at_goal !== 1'b1 || bus.move_ready !== 1'b0 || bus.pos_x !== 3'd7 || bus.pos_y !== 3'd7) begin
            n_fail++;
            $display("FAIL ones_goal: goal=%b ready=%b pos=(%0d,%0d) want 1 0 (7,7)",
                     bus.at_goal, bus.move_ready, bus.pos_x, bus.pos_y);
        end
        do_load("ones_reload", 1'b0);
        dq = {2'b01, 2'b11};
        do_moves("ones_after_reload");
    endtask

    task automatic test_err();
        set_map(64'h00000000000000FE);
        do_load("err_load", 1'b0);
        dq = {2'b11};
        do_moves("err_move_ignored");
        map[0] = 8'h01;
        do_load("err_recover", 1'b0);
        dq = {2'b11, 2'b01};
        do_moves("err_recover_moves");
    endtask

    task automatic test_rst_mid_load();
        set_map({8{8'hFF}});
        do_load("rst_preload", 1'b0);
        dq = {2'b11};
        do_moves("rst_premove");
        set_map(64'hE4B6928EEA27FC0F);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (bus.rom_en !== 1'b1 || bus.rom_addr !== 3'd3) begin
            n_fail++;
            $display("FAIL rst_cycle4: en=%b addr=%0d want 1 3", bus.rom_en, bus.rom_addr);
        end
        #1 rst = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        test_reset();
        do_load("rst_reload", 1'b0);
        dq = {2'b11, 2'b11, 2'b11, 2'b01, 2'b01};
        do_moves("rst_reload_moves");
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < 8; r++) map[r] = 8'($urandom);
            if (t != 3) map[0][0] = 1'b1;
            do_load("rand_load", 1'b0);
            dq = {};
            for (int i = 0; i < 30; i++) dq.push_back(2'($urandom_range(0, 3)));
            do_moves("rand_walk");
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.move_valid = 1'b0;
        bus.move_dir = 2'b00;
        set_map(64'h0);
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_standard_map();
        test_back_to_back_goal();
        test_err();
        test_rst_mid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/maze_walker.md
# maze_walker

Reads the 8x8 maze map out of the map ROM, row by row, into an internal cell array. It then serves player move requests against that map and tracks the player position until the goal cell is reached. It sits between the map ROM (synchronous read, one-cycle latency) and the game controller or input logic.

## Interface
- START_X, 0, start column (0..7)
- START_Y, 0, start row (0..7)
- GOAL_X, 7, goal column (0..7)
- GOAL_Y, 7, goal row (0..7)

Ports:
- clk  in  1  system clock; everything on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse: (re)load map and place player at start
- rom_en  out  1  ROM read enable
- rom_addr  out  3  ROM row address
- rom_data  in  9  ROM row data; bit x = column x, 1 = open, 0 = wall; bit 8 ignored
- move_valid  in  1  move request
- move_dir  in  2  00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
- move_ready  out  1  move requests accepted this cycle
- move_done  out  1  one-cycle pulse, the cycle after an accepted move
- move_ok  out  1  result of last move; valid with move_done; holds until the next move_done
- pos_x, pos_y  out  3 each  current player column and row
- loaded  out  1  map loaded and start cell open
- at_goal  out  1  player is on the goal cell
- err  out  1  start cell is a wall

## Operation
States: IDLE, LOAD, CHECK, PLAY, GOAL, ERR.
- Reset: state IDLE. All outputs 0, with pos_x=START_X and pos_y=START_Y. Cell array cleared to 0.
- IDLE: start -> LOAD. All other inputs are ignored.
- LOAD:
  - rom_en=1 for exactly 8 consecutive cycles, rom_addr=0,1,...,7.
  - Row r is captured from rom_data[7:0] on the edge after the edge that presented addr r.
  - The last capture happens one cycle after rom_en falls. Then -> CHECK.
  - start is ignored during LOAD.
- CHECK (1 cycle):
  - pos := (START_X, START_Y).
  - If that cell is open -> PLAY and loaded=1. Otherwise -> ERR and err=1.
- PLAY:
  - move_ready=1.
  - On move_valid&move_ready, the target cell is computed from the current position and move_dir.
  - The move is accepted (move_ok=1, pos updated) only if the target is inside 0..7 on both axes and the target cell is open.
  - Otherwise the move is blocked: move_ok=0 and pos is unchanged.
  - No wrap-around. Moving up at y=0 or left at x=0 is blocked; so is moving down at y=7 or right at x=7.
- GOAL:
  - Entered on the same edge as an accepted move onto (GOAL_X, GOAL_Y). at_goal=1 from that edge.
  - move_ready=0. Requests are ignored; no move_done.
- ERR: move_ready=0, loaded=0, err=1.
- start in PLAY, GOAL or ERR behaves like start in IDLE:
  - loaded, at_goal, err and move_ok clear, and the state goes to LOAD.
  - pos stays until CHECK.
- A start and a move_valid in the same PLAY cycle: start wins and the move is dropped (no move_done).
- START equal to GOAL: CHECK goes to PLAY, and at_goal=1 immediately. The first move that leaves the goal clears at_goal.

## Timing
- Load latency: start sampled at edge 0; rom_en high during cycles 1..8.
- Last row captured at edge 9. CHECK occupies cycle 10. loaded/err is visible after edge 10, i.e. 10 cycles after start.
- Moves:
  - Throughput is one move per cycle.
  - A request sampled at edge N updates pos and drives move_done=1 and move_ok after edge N.
  - Back-to-back requests each evaluate against the already-updated pos.
- rst mid-LOAD: immediate return to the reset values. rom_en=0 without waiting for a clock, and the partially loaded map is discarded.

## Test plan
- Standard map (rows 0..7: 0x0F, 0xFC, 0x27, 0xEA, 0x8E, 0x92, 0xB6, 0xE4), start pulse -> rom_addr 0..7 on 8 consecutive cycles; loaded=1 exactly 10 cycles after start; pos=(0,0); err=0.
- Standard map, move right -> move_done with move_ok=1, pos=(1,0); then move up -> move_ok=0, pos=(1,0).
- Standard map from (0,0), move down -> row1 bit0=0, so move_ok=0. Then right, right, down -> pos=(2,1), all ok.
- All-ones map: 7 rights then 7 downs back-to-back -> pos=(7,7), at_goal=1 after the 14th move, move_ready=0. A further move_valid produces no move_done. A start pulse reloads the map and returns pos to (0,0).
- Map with row0=0xFE -> err=1, loaded=0, move_ready=0. A start with row0=0x01 then gives loaded=1.
- rst pulse during LOAD cycle 4 -> rom_en=0 and all outputs at reset values. A following start performs a full 8-row load.
